// File: rtl/conv_y_maxpool.sv
// ---------------------------------------------------------------------------
// conv_y_maxpool
//
// Max-pooling stage placed after the convolution's y result stream. It emits
// the signed maximum of every POOL consecutive samples. Windows restart at
// each frame boundary (FRAME samples per frame), and a short trailing window
// at the end of a frame is flushed as its own result.
//
// Parameters:
//   POOL  - samples per pooling window (>=1, 1 gives pass-through)
//   FRAME - input samples per frame (>=1)
//   W     - data width, signed two's complement
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   s_data_in_y   in   signed input sample
//   s_valid_y     in   input sample valid
//   s_ready_y     out  block can accept an input sample
//   m_data_out_z  out  signed pooled result
//   m_valid_z     out  pooled result valid
//   m_ready_z     in   downstream accepts the result
//
// Build option:
//   CONV_Y_RELU_EN - when defined, every accepted sample is clamped at zero
//                    before the compare, so results are never negative.
// ---------------------------------------------------------------------------
module conv_y_maxpool #(
    parameter int POOL  = 4,
    parameter int FRAME = 97,
    parameter int W     = 21
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] s_data_in_y,
    input  logic         s_valid_y,
    output logic         s_ready_y,
    output logic [W-1:0] m_data_out_z,
    output logic         m_valid_z,
    input  logic         m_ready_z
);

    localparam int WC = (POOL  > 1) ? $clog2(POOL)  : 1;
    localparam int WF = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [WC-1:0] WIN_LAST = WC'(POOL - 1);
    localparam logic [WF-1:0] FRM_LAST = WF'(FRAME - 1);

    // Signed maximum, no width growth.
    function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        return (b > a) ? b : a;
    endfunction

`ifdef CONV_Y_RELU_EN
    // Clamp negative samples to zero.
    function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] a);
        return a[W-1] ? '0 : a;
    endfunction
`endif

    logic signed [W-1:0] max_q;
    logic signed [W-1:0] z_q;
    logic signed [W-1:0] x_c;
    logic signed [W-1:0] cand;
    logic [WC-1:0]       win_cnt;
    logic [WF-1:0]       frm_cnt;
    logic                first;
    logic                close;
    logic                accept;

`ifdef CONV_Y_RELU_EN
    assign x_c = relu($signed(s_data_in_y));
`else
    assign x_c = $signed(s_data_in_y);
`endif

    // Window close is decided from the counters alone, so s_ready_y never
    // depends on s_valid_y or on the incoming data.
    assign first  = (win_cnt == '0);
    assign close  = (win_cnt == WIN_LAST) || (frm_cnt == FRM_LAST);
    assign cand   = first ? x_c : smax(max_q, x_c);

    // Only a closing sample needs the output register; it may proceed when
    // the register is empty or is being drained in the same cycle.
    assign s_ready_y = !close || !m_valid_z || m_ready_z;
    assign accept    = s_valid_y && s_ready_y;

    assign m_data_out_z = z_q;

    // Stage boundary: accepted sample -> running max / registered result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_q     <= '0;
            z_q       <= '0;
            m_valid_z <= 1'b0;
            win_cnt   <= '0;
            frm_cnt   <= '0;
        end else begin
            if (m_valid_z && m_ready_z) begin
                m_valid_z <= 1'b0;
            end
            if (accept) begin
                if (close) begin
                    // A new result loaded here overrides the clear above.
                    z_q       <= cand;
                    m_valid_z <= 1'b1;
                    win_cnt   <= '0;
                    frm_cnt   <= (frm_cnt == FRM_LAST) ? '0 : frm_cnt + 1'b1;
                end else begin
                    max_q   <= cand;
                    win_cnt <= win_cnt + 1'b1;
                    frm_cnt <= frm_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_y_maxpool.sv
module tb_conv_y_maxpool;

    localparam int W           = 21;
    localparam int POOL        = 4;
    localparam int FRAME       = 97;
    localparam int OUT_PER_FRM = 25;
    localparam int RAND_FRAMES = 250;

    typedef logic signed [W-1:0] sw_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] s_data_in_y;
    logic         s_valid_y;
    logic         s_ready_y;
    logic [W-1:0] m_data_out_z;
    logic         m_valid_z;
    logic         m_ready_z;

    always #5 clk = ~clk;

    conv_y_maxpool #(.POOL(POOL), .FRAME(FRAME), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data_in_y),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .m_data_out_z (m_data_out_z),
        .m_valid_z    (m_valid_z),
        .m_ready_z    (m_ready_z)
    );

    int  errors = 0;
    int  checks = 0;

    // Reference model state: samples of the open window, position in frame,
    // and results that have closed but not yet been taken downstream.
    sw_t win[$];
    sw_t expq[$];
    sw_t out_log[$];
    int  fpos    = 0;
    int  acc_cnt = 0;
    int  out_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic sw_t model_in(input sw_t x);
`ifdef CONV_Y_RELU_EN
        return (x < 0) ? sw_t'(0) : x;
`else
        return x;
`endif
    endfunction

    function automatic sw_t qmax(input sw_t q[$]);
        sw_t m;
        m = q[0];
        foreach (q[i]) if (q[i] > m) m = q[i];
        return m;
    endfunction

    // Compare process: inputs change just after the rising edge, so at the
    // falling edge everything is settled and the handshakes seen here are
    // exactly the ones the next rising edge will perform.
    always @(negedge clk) begin : mon
        bit  exp_valid;
        bit  close_next;
        bit  exp_ready;
        sw_t x;
        if (reset) begin
            win.delete();
            expq.delete();
            fpos = 0;
        end else begin
            exp_valid = (expq.size() != 0);
            chk("m_valid_z", int'(m_valid_z), int'(exp_valid));
            if (exp_valid)
                chk("m_data_out_z", int'(sw_t'(m_data_out_z)), int'(expq[0]));
            close_next = (win.size() == POOL - 1) || (fpos == FRAME - 1);
            exp_ready  = !close_next || !exp_valid || m_ready_z;
            chk("s_ready_y", int'(s_ready_y), int'(exp_ready));

            if (m_valid_z && m_ready_z) begin
                if (expq.size() != 0) void'(expq.pop_front());
                out_log.push_back(sw_t'(m_data_out_z));
                out_cnt++;
            end
            if (s_valid_y && s_ready_y) begin
                x = model_in(sw_t'(s_data_in_y));
                win.push_back(x);
                fpos++;
                acc_cnt++;
                if (win.size() == POOL || fpos == FRAME) begin
                    expq.push_back(qmax(win));
                    win.delete();
                end
                if (fpos == FRAME) fpos = 0;
            end
        end
    end

    // Called just after a rising edge; returns just after the rising edge
    // that accepted the sample, leaving s_valid_y low.
    task automatic send(input int v);
        int t;
        s_valid_y   = 1'b1;
        s_data_in_y = W'(v);
        t = 0;
        @(negedge clk);
        while (!s_ready_y && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_timeout", int'(t >= 200), 0);
        @(posedge clk);
        #1;
        s_valid_y   = 1'b0;
        s_data_in_y = 'x;
    endtask

    task automatic drain();
        m_ready_z = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  acc0;
        int  out0;
        int  target;
        int  cyc;
        int  mode;
        sw_t extremes [4];

        reset       = 1'b1;
        s_valid_y   = 1'b0;
        s_data_in_y = '0;
        m_ready_z   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_m_valid", int'(m_valid_z), 0);
        chk("rst_m_data",  int'(sw_t'(m_data_out_z)), 0);
        chk("rst_s_ready", int'(s_ready_y), 1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Inputs 1..8 back to back
        out_log.delete();
        for (int i = 1; i <= 8; i++) send(i);
        drain();
        chk("t1_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("t1_out0", int'(out_log[0]), 4);
            chk("t1_out1", int'(out_log[1]), 8);
        end

        // All-negative window
        pulse_reset();
        out_log.delete();
        send(-5); send(-2); send(-9); send(-7);
        drain();
        chk("t2_count", out_log.size(), 1);
        if (out_log.size() == 1) begin
`ifdef CONV_Y_RELU_EN
            chk("t2_out", int'(out_log[0]), 0);
`else
            chk("t2_out", int'(out_log[0]), -2);
`endif
        end

        // Full frame 0..96 then the first window of the next frame
        pulse_reset();
        out_log.delete();
        for (int i = 0; i < FRAME; i++) send(i);
        for (int i = 0; i < 4; i++) send(100 + i);
        drain();
        chk("t3_count", out_log.size(), 26);
        if (out_log.size() == 26) begin
            for (int k = 0; k < 24; k++) chk("t3_win", int'(out_log[k]), 4 * k + 3);
            chk("t3_tail",  int'(out_log[24]), 96);
            chk("t3_next",  int'(out_log[25]), 103);
        end

        // Backpressure: the 8th sample closes a window while 4 is held
        pulse_reset();
        out_log.delete();
        m_ready_z = 1'b0;
        for (int i = 1; i <= 7; i++) send(i);
        s_valid_y   = 1'b1;
        s_data_in_y = W'(8);
        repeat (3) @(negedge clk);
        chk("t4_stall_ready", int'(s_ready_y), 0);
        chk("t4_held_valid",  int'(m_valid_z), 1);
        chk("t4_held_data",   int'(sw_t'(m_data_out_z)), 4);
        @(posedge clk);
        #1 m_ready_z = 1'b1;
        @(negedge clk);
        chk("t4_release_ready", int'(s_ready_y), 1);
        @(posedge clk);
        #1 s_valid_y = 1'b0;
        drain();
        chk("t4_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("t4_out0", int'(out_log[0]), 4);
            chk("t4_out1", int'(out_log[1]), 8);
        end

        // Reset in the middle of a window
        pulse_reset();
        out_log.delete();
        send(50); send(60);
        pulse_reset();
        send(10); send(20); send(30); send(40);
        drain();
        chk("t5_count", out_log.size(), 1);
        if (out_log.size() == 1) chk("t5_out", int'(out_log[0]), 40);

        // Random valid/ready stream over whole frames
        pulse_reset();
        extremes[0] = {1'b1, {(W-1){1'b0}}};
        extremes[1] = {1'b0, {(W-1){1'b1}}};
        extremes[2] = '1;
        extremes[3] = '0;
        acc0   = acc_cnt;
        out0   = out_cnt;
        target = RAND_FRAMES * FRAME;
        for (cyc = 0; cyc < 80000; cyc++) begin
            if (acc_cnt - acc0 >= target) break;
            s_valid_y = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 2);
            if (mode == 0)
                s_data_in_y = W'($urandom);
            else if (mode == 1)
                s_data_in_y = W'($signed($urandom_range(0, 15)) - 8);
            else
                s_data_in_y = extremes[$urandom_range(0, 3)];
            m_ready_z = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        s_valid_y = 1'b0;
        drain();
        chk("rand_accepts", acc_cnt - acc0, target);
        chk("rand_outputs", out_cnt - out0, RAND_FRAMES * OUT_PER_FRM);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
